comp_boot_ctrl: RTL and testbench

Synthesizable boot/run sequencer for the `comp` core. It streams a program image into core memory over the out-of-band write port while holding the core in reset, then releases reset. While the core runs it captures every `outen`/`outflen` word into an output FIFO. It stops on `halt` or on a watchdog timeout and re-freezes the core. This replaces the behavioural load/capture loop in simulation drivers and lets a host or FPGA wrapper run programs unattended.

---
 rtl/comp_boot_ctrl.sv | 144 ++++++++++++++
 tb/tb_comp_boot_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/comp_boot_ctrl.sv
// comp_boot_ctrl: boots the comp core from a host image, runs it under a watchdog and captures its outputs in a FIFO.
// Define COMP_BOOT_CLEAR_EN to zero-fill core memory above the loaded image before release.
module comp_boot_ctrl #(
  parameter int MEM_WORDS      = 256,
  parameter int OUT_DEPTH      = 32,
  parameter int TIMEOUT_CYCLES = 600,
  parameter int LEN_W          = $clog2(MEM_WORDS) + 1,
  parameter int CNT_W          = $clog2(OUT_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] prog_len,
  input  logic             ld_valid,
  input  logic [31:0]      ld_data,
  output logic             ld_ready,
  output logic             core_rst,
  output logic             oob_wen,
  output logic [31:0]      oob_wr_addr,
  output logic [31:0]      oob_wr_data,
  input  logic [31:0]      core_out,
  input  logic             core_outen,
  input  logic             core_outflen,
  input  logic             core_halt,
  input  logic             rd_en,
  output logic [31:0]      rd_data,
  output logic             rd_type,
  output logic             rd_empty,
  output logic [CNT_W-1:0] out_count,
  output logic             busy,
  output logic             done,
  output logic             timed_out,
  output logic             overflow,
  output logic [31:0]      run_cycles
);
  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam logic [LEN_W-1:0] MEM_LEN = LEN_W'(MEM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
`ifdef COMP_BOOT_CLEAR_EN
    S_CLEAR,
`endif
    S_SETTLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state, w_next, w_tail;
  logic [LEN_W-1:0] r_len, r_idx, w_len;
  logic [31:0] r_addr, r_wdata, r_cycles;
  logic r_wen, r_to, r_ovf;
  logic [32:0] r_mem [OUT_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [CNT_W-1:0] r_cnt;
  logic w_start, w_acc, w_last, w_clr, w_run, w_tmo, w_full, w_pop, w_push, w_wr;

`ifdef COMP_BOOT_CLEAR_EN
  localparam state_t S_EMPTY = S_CLEAR;
  assign w_tail = (r_len == MEM_LEN) ? S_SETTLE : S_CLEAR;
  assign w_clr  = r_state == S_CLEAR;
`else
  localparam state_t S_EMPTY = S_SETTLE;
  assign w_tail = S_SETTLE;
  assign w_clr  = 1'b0;
`endif

  assign w_start = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_len   = (prog_len > MEM_LEN) ? MEM_LEN : prog_len;
  assign w_acc   = (r_state == S_LOAD) && ld_valid;
  assign w_last  = w_acc && (r_idx + LEN_W'(1) == r_len);
  assign w_run   = r_state == S_RUN;
  // halt takes priority, so a halting cycle never counts as a timeout
  assign w_tmo   = w_run && !core_halt && (r_cycles == 32'(TIMEOUT_CYCLES - 1));
  assign w_full  = r_cnt == CNT_W'(OUT_DEPTH);
  assign w_pop   = rd_en && (r_cnt != '0);
  assign w_push  = w_run && (core_outen || core_outflen);
  assign w_wr    = w_push && (!w_full || w_pop);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = (w_len == '0) ? S_EMPTY : S_LOAD;
      S_LOAD:         if (w_last) w_next = w_tail;
`ifdef COMP_BOOT_CLEAR_EN
      S_CLEAR:        if (r_idx == MEM_LEN - LEN_W'(1)) w_next = S_SETTLE;
`endif
      S_SETTLE:       w_next = S_RUN;
      S_RUN:          if (core_halt || w_tmo) w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_len    <= '0;
      r_idx    <= '0;
      r_wen    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_cycles <= '0;
      r_to     <= 1'b0;
      r_ovf    <= 1'b0;
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      r_wen   <= w_acc || w_clr;
      if (w_acc || w_clr) begin
        r_addr  <= 32'(r_idx);
        r_wdata <= w_acc ? ld_data : '0;
      end
      if (w_start) r_len <= w_len;
      r_idx    <= w_start ? '0 : (w_acc || w_clr) ? r_idx + LEN_W'(1) : r_idx;
      r_cycles <= w_start ? '0 : w_run ? r_cycles + 32'd1 : r_cycles;
      r_to     <= w_start ? 1'b0 : r_to | w_tmo;
      r_ovf    <= w_start ? 1'b0 : r_ovf | (w_push && !w_wr);
      r_wp     <= w_start ? '0 : r_wp + PW'(w_wr);
      r_rp     <= w_start ? '0 : r_rp + PW'(w_pop);
      r_cnt    <= w_start ? '0 : r_cnt + CNT_W'(w_wr) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp] <= {core_outflen, core_out};

  assign ld_ready    = r_state == S_LOAD;
  assign core_rst    = !w_run;
  assign oob_wen     = r_wen;
  assign oob_wr_addr = r_addr;
  assign oob_wr_data = r_wdata;
  assign rd_data     = r_mem[r_rp][31:0];
  assign rd_type     = r_mem[r_rp][32];
  assign rd_empty    = r_cnt == '0;
  assign out_count   = r_cnt;
  assign busy        = !(r_state == S_IDLE || r_state == S_DONE);
  assign done        = r_state == S_DONE;
  assign timed_out   = r_to;
  assign overflow    = r_ovf;
  assign run_cycles  = r_cycles;
endmodule

// File: tb/tb_comp_boot_ctrl.sv
// tb_comp_boot_ctrl: scoreboard bench for comp_boot_ctrl; memory writes and FIFO reads are checked against queued expectations.
module tb_comp_boot_ctrl;
`ifdef COMP_BOOT_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, start, ld_valid, ld_ready, core_rst, oob_wen;
  logic [8:0] prog_len;
  logic [31:0] ld_data, oob_wr_addr, oob_wr_data, core_out, rd_data, run_cycles;
  logic core_outen, core_outflen, core_halt, rd_en, rd_type, rd_empty;
  logic busy, done, timed_out, overflow;
  logic [5:0] out_count;

  logic [63:0] wq[$];
  logic [32:0] fq[$];
  int n_chk = 0;
  int n_err = 0;

  comp_boot_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_len(prog_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .core_rst(core_rst), .oob_wen(oob_wen), .oob_wr_addr(oob_wr_addr),
    .oob_wr_data(oob_wr_data), .core_out(core_out), .core_outen(core_outen),
    .core_outflen(core_outflen), .core_halt(core_halt), .rd_en(rd_en),
    .rd_data(rd_data), .rd_type(rd_type), .rd_empty(rd_empty),
    .out_count(out_count), .busy(busy), .done(done), .timed_out(timed_out),
    .overflow(overflow), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (rst_n && oob_wen) begin
      if (wq.size() == 0) chk("wr_extra", oob_wen, 0);
      else begin
        chk("wr_addr", oob_wr_addr, wq[0][63:32]);
        chk("wr_data", oob_wr_data, wq[0][31:0]);
        void'(wq.pop_front());
      end
    end

  task automatic do_start(input int len);
    start = 1'b1;
    prog_len = 9'(len);
    fq.delete();
    tick();
    start = 1'b0;
  endtask

  task automatic boot(input int len, input int n, input logic [31:0] base);
    do_start(len);
    chk("busy_boot", busy, 1);
    chk("wen_first", oob_wen, 0);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data = base + 32'(i);
      wq.push_back({32'(i), base + 32'(i)});
      tick();
    end
    ld_valid = 1'b0;
    if (CLR) for (int a = n; a < 256; a++) wq.push_back({32'(a), 32'd0});
    repeat (CLR ? 256 - n : 0) tick();
    chk("settle_rst", core_rst, 1);
    chk("settle_rdy", ld_ready, 0);
    tick();
    chk("run_rst", core_rst, 0);
  endtask

  task automatic emit(input logic [31:0] d, input logic fl, input logic ie, input logic h);
    core_out = d;
    core_outflen = fl;
    core_outen = ie;
    core_halt = h;
    if ((fl || ie) && fq.size() < 32) fq.push_back({fl, d});
    tick();
    core_outen = 1'b0;
    core_outflen = 1'b0;
    core_halt = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (!rd_empty && k < 40) begin
      if (fq.size() == 0) chk("drain_extra", rd_empty, 1);
      else begin
        chk("rd_data", rd_data, fq[0][31:0]);
        chk("rd_type", rd_type, fq[0][32]);
        void'(fq.pop_front());
      end
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      k++;
    end
    chk("rd_empty", rd_empty, 1);
    chk("fq_left", fq.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got 0 exp 1");
    $fatal(1);
  end

  initial begin
    int k;
    rst_n = 1'b0; start = 1'b0; prog_len = '0; ld_valid = 1'b0; ld_data = '0;
    core_out = '0; core_outen = 1'b0; core_outflen = 1'b0; core_halt = 1'b0; rd_en = 1'b0;
    repeat (3) tick();
    chk("rst_core_rst", core_rst, 1);
    chk("rst_wen", oob_wen, 0);
    chk("rst_addr", oob_wr_addr, 0);
    chk("rst_data", oob_wr_data, 0);
    chk("rst_empty", rd_empty, 1);
    chk("rst_cnt", out_count, 0);
    chk("rst_flags", {busy, done, timed_out, overflow}, 0);
    chk("rst_cycles", run_cycles, 0);
    rst_n = 1'b1;
    tick();

    boot(4, 4, 32'hA);
    chk("run_busy", busy, 1);
    start = 1'b1;
    emit(32'd5, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    emit(32'h3F80_0000, 1'b1, 1'b0, 1'b0);
    emit(32'd7, 1'b0, 1'b1, 1'b1);
    chk("halt_done", done, 1);
    chk("halt_to", timed_out, 0);
    chk("halt_cnt", out_count, 3);
    chk("halt_rst", core_rst, 1);
    chk("halt_busy", busy, 0);
    chk("halt_cycles", run_cycles, 3);
    drain();

    boot(0, 0, 32'h0);
    k = 0;
    while (!done && k < 1000) begin
      tick();
      k++;
    end
    chk("wd_wait", k, 600);
    chk("wd_done", done, 1);
    chk("wd_cycles", run_cycles, 600);
    chk("wd_to", timed_out, 1);
    chk("wd_rst", core_rst, 1);

    boot(0, 0, 32'h0);
    chk("restart_to", timed_out, 0);
    repeat (599) tick();
    emit(32'd9, 1'b0, 1'b1, 1'b1);
    chk("tie_done", done, 1);
    chk("tie_to", timed_out, 0);
    chk("tie_cycles", run_cycles, 600);
    drain();

    boot(1, 1, 32'h1234);
    for (int i = 0; i < 33; i++) emit(32'(i), 1'b0, 1'b1, 1'b0);
    chk("full_cnt", out_count, 32);
    chk("full_ovf", overflow, 1);
    chk("full_head", rd_data, fq[0][31:0]);
    void'(fq.pop_front());
    rd_en = 1'b1;
    emit(32'd100, 1'b0, 1'b1, 1'b0);
    rd_en = 1'b0;
    chk("pp_cnt", out_count, 32);
    emit(32'd0, 1'b0, 1'b0, 1'b1);
    chk("full_done", done, 1);
    chk("ovf_sticky", overflow, 1);
    drain();

    do_start(4);
    ld_valid = 1'b1; ld_data = 32'h11; wq.push_back({32'd0, 32'h11});
    tick();
    ld_valid = 1'b0;
    tick();
    chk("gap_wen", oob_wen, 0);
    ld_valid = 1'b1; ld_data = 32'h22; wq.push_back({32'd1, 32'h22});
    tick();
    ld_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_rst", core_rst, 1);
    chk("abort_wen", oob_wen, 0);
    chk("abort_state", {busy, done, ld_ready}, 0);
    #2 rst_n = 1'b1;
    tick();
    boot(2, 2, 32'h55);
    emit(32'd0, 1'b0, 1'b0, 1'b1);
    chk("reload_done", done, 1);

    boot(254, 254, 32'h1000);
    emit(32'd0, 1'b0, 1'b0, 1'b1);
    chk("p254_done", done, 1);

    boot(300, 256, 32'h2000);
    emit(32'd0, 1'b0, 1'b0, 1'b1);
    chk("sat_done", done, 1);

    tick();
    chk("wq_left", wq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
